// File: rtl/timer_pkg.sv
// Shared definitions for the minutes:seconds countdown stage.
package timer_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // Status-only state machine; the digit datapath never depends on it.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown: parallel load for key entry, decrement with
// borrow for run mode. Load has priority over decrement.
import timer_pkg::*;

module bcd_down_digit (
    input  logic               clk,
    input  logic               clearn,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               dec,
    input  logic [DIGIT_W-1:0] wrap_val,
    output logic [DIGIT_W-1:0] q,
    output logic               borrow_out
);

    // A borrow leaves this digit only when it is asked to count below zero.
    assign borrow_out = dec && (q == '0);

    // Digit register: load a keyed value, or step down wrapping to wrap_val.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (dec) begin
            q <= (q == '0) ? wrap_val : q - 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// M:SS countdown stage: shifts keyed digits in while loadn is low, counts
// down once per synchronized pgt_1Hz edge while loadn is high, and pulses
// done for one clock when a decrement lands on 0:00.
import timer_pkg::*;

module countdown_timer #(
    parameter int SYNC_STAGES = 2,
    parameter int TENS_WRAP   = 5
) (
    input  logic               clk,
    input  logic               clearn,
    input  logic               pgt_1Hz,
    input  logic               loadn,
    input  logic [DIGIT_W-1:0] bcd,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic               zero,
    output logic               done,
    output state_t             fsm_state
);

    logic [SYNC_STAGES-1:0] pgt_sync;
    logic [SYNC_STAGES-1:0] loadn_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   pgt_s;
    logic                   loadn_s;
    logic                   pgt_prev;
    logic                   armed;
    logic                   step;
    logic                   entry_load;
    logic                   run_dec;
    logic                   borrow_ones;
    logic                   borrow_tens;
    logic                   borrow_min;
    logic                   at_one;
    logic                   entry_to_zero;
    state_t                 state;
    state_t                 state_next;

    assign pgt_s   = pgt_sync[SYNC_STAGES-1];
    assign loadn_s = loadn_sync[SYNC_STAGES-1];

    // Synchronizers; fill marks when pgt_s carries real samples after reset.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            pgt_sync   <= '0;
            loadn_sync <= '0;
            fill       <= '0;
            pgt_prev   <= 1'b0;
            armed      <= 1'b0;
        end else begin
            pgt_sync   <= {pgt_sync[SYNC_STAGES-2:0], pgt_1Hz};
            loadn_sync <= {loadn_sync[SYNC_STAGES-2:0], loadn};
            fill       <= {fill[SYNC_STAGES-2:0], 1'b1};
            pgt_prev   <= pgt_s;
            // A pgt held high through reset release must go low before it
            // can count as an edge.
            if (fill[SYNC_STAGES-1] && !pgt_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign step       = pgt_s && !pgt_prev && armed;
    assign zero       = (sec_ones == '0) && (sec_tens == '0) && (min_ones == '0);
    assign entry_load = step && !loadn_s && (bcd <= BCD_MAX);
    assign run_dec    = step && loadn_s && !zero;
    assign at_one     = (min_ones == '0) && (sec_tens == '0) && (sec_ones == 4'd1);
    assign entry_to_zero = (bcd == '0) && (sec_ones == '0) && (sec_tens == '0);

    bcd_down_digit u_sec_ones (
        .clk        (clk),
        .clearn     (clearn),
        .load       (entry_load),
        .load_val   (bcd),
        .dec        (run_dec),
        .wrap_val   (BCD_MAX),
        .q          (sec_ones),
        .borrow_out (borrow_ones)
    );

    bcd_down_digit u_sec_tens (
        .clk        (clk),
        .clearn     (clearn),
        .load       (entry_load),
        .load_val   (sec_ones),
        .dec        (borrow_ones),
        .wrap_val   (DIGIT_W'(TENS_WRAP)),
        .q          (sec_tens),
        .borrow_out (borrow_tens)
    );

    // Minutes never borrow further: run_dec is gated by zero, so a borrow
    // reaching here always finds a non-zero minute digit.
    bcd_down_digit u_min_ones (
        .clk        (clk),
        .clearn     (clearn),
        .load       (entry_load),
        .load_val   (sec_tens),
        .dec        (borrow_tens),
        .wrap_val   ('0),
        .q          (min_ones),
        .borrow_out (borrow_min)
    );

    // State register.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the status machine.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (entry_load && ((bcd != '0) || !zero)) begin
                    state_next = ENTRY;
                end
            end
            ENTRY: begin
                if (step && loadn_s) begin
                    state_next = zero ? EMPTY : RUN;
                end else if (entry_load && entry_to_zero) begin
                    state_next = EMPTY;
                end
            end
            RUN: begin
                if (step && !loadn_s) begin
                    state_next = ENTRY;
                end else if (run_dec && at_one) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = EMPTY;
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    assign done      = (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: entry, borrow chain, large tens,
// overflow entry and mid-run reset, with hand-computed expected digits.
import timer_pkg::*;

module tb_countdown_timer;

    logic         clk;
    logic         clearn;
    logic         pgt_1Hz;
    logic         loadn;
    logic [3:0]   bcd;
    logic [3:0]   sec_ones;
    logic [3:0]   sec_tens;
    logic [3:0]   min_ones;
    logic         zero;
    logic         done;
    state_t       fsm_state;

    int n_checks;
    int n_pass;
    int done_cnt;

    countdown_timer #(
        .SYNC_STAGES (2),
        .TENS_WRAP   (5)
    ) dut (
        .clk       (clk),
        .clearn    (clearn),
        .pgt_1Hz   (pgt_1Hz),
        .loadn     (loadn),
        .bcd       (bcd),
        .sec_ones  (sec_ones),
        .sec_tens  (sec_tens),
        .min_ones  (min_ones),
        .zero      (zero),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] digits();
        return {min_ones, sec_tens, sec_ones};
    endfunction

    // One pgt pulse, 4 cycles high then 4 low, with bcd held; counts done.
    task automatic pulse(input logic [3:0] d, output int dn);
        dn  = 0;
        bcd = d;
        for (int i = 0; i < 8; i++) begin
            pgt_1Hz = (i < 4);
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        pgt_1Hz = 1'b0;
    endtask

    task automatic set_loadn(input logic v);
        loadn = v;
        repeat (4) @(negedge clk);
    endtask

    task automatic key3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        int dn;
        pulse(a, dn);
        pulse(b, dn);
        pulse(c, dn);
    endtask

    task automatic run_n(input int n, output int dn_total);
        int dn;
        dn_total = 0;
        for (int i = 0; i < n; i++) begin
            pulse(4'd0, dn);
            dn_total += dn;
        end
    endtask

    initial begin
        int dn;
        n_checks = 0;
        n_pass   = 0;
        clearn   = 1'b0;
        pgt_1Hz  = 1'b0;
        loadn    = 1'b0;
        bcd      = 4'd0;

        // Reset with pgt toggling.
        for (int i = 0; i < 6; i++) begin
            pgt_1Hz = ~pgt_1Hz;
            @(negedge clk);
        end
        pgt_1Hz = 1'b0;
        check("reset_digits", 32'(digits()), 32'h000);
        check("reset_zero", 32'(zero), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_state", 32'(fsm_state), 32'(EMPTY));
        clearn = 1'b1;
        repeat (5) @(negedge clk);

        // Entry 1,3,0 -> 1:30; invalid digit ignored.
        key3(4'd1, 4'd3, 4'd0);
        check("entry_130", 32'(digits()), 32'h130);
        check("entry_state", 32'(fsm_state), 32'(ENTRY));
        check("entry_zero", 32'(zero), 32'd0);
        pulse(4'hC, dn);
        check("entry_bad_bcd", 32'(digits()), 32'h130);

        // Borrow chain from 1:00.
        key3(4'd1, 4'd0, 4'd0);
        check("entry_100", 32'(digits()), 32'h100);
        set_loadn(1'b1);
        pulse(4'd0, dn);
        check("borrow_059", 32'(digits()), 32'h059);
        check("borrow_059_done", 32'(dn), 32'd0);
        check("run_state", 32'(fsm_state), 32'(RUN));
        run_n(58, dn);
        check("count_001", 32'(digits()), 32'h001);
        check("count_001_done", 32'(dn), 32'd0);
        pulse(4'd0, dn);
        check("reach_000", 32'(digits()), 32'h000);
        check("reach_done_once", 32'(dn), 32'd1);
        check("reach_zero", 32'(zero), 32'd1);
        check("after_done_state", 32'(fsm_state), 32'(EMPTY));
        run_n(2, dn);
        check("hold_000", 32'(digits()), 32'h000);
        check("hold_no_done", 32'(dn), 32'd0);

        // Large tens: 0:99 counts 10 to 0:89.
        set_loadn(1'b0);
        key3(4'd0, 4'd9, 4'd9);
        check("entry_099", 32'(digits()), 32'h099);
        set_loadn(1'b1);
        run_n(10, dn);
        check("large_089", 32'(digits()), 32'h089);

        // 1:05 -> 1:00 -> 0:59.
        set_loadn(1'b0);
        key3(4'd1, 4'd0, 4'd5);
        check("entry_105", 32'(digits()), 32'h105);
        set_loadn(1'b1);
        run_n(5, dn);
        check("count_100", 32'(digits()), 32'h100);
        pulse(4'd0, dn);
        check("wrap_059", 32'(digits()), 32'h059);

        // Overflow entry from 0:59: keys 1,2,3,4 -> 2:34.
        set_loadn(1'b0);
        key3(4'd1, 4'd2, 4'd3);
        pulse(4'd4, dn);
        check("overflow_234", 32'(digits()), 32'h234);

        // Mid-run reset at 0:45.
        key3(4'd0, 4'd4, 4'd5);
        check("entry_045", 32'(digits()), 32'h045);
        set_loadn(1'b1);
        pulse(4'd0, dn);
        check("count_044", 32'(digits()), 32'h044);
        pgt_1Hz = 1'b1;
        @(negedge clk);
        clearn = 1'b0;
        #1;
        check("async_clear", 32'(digits()), 32'h000);
        check("async_clear_state", 32'(fsm_state), 32'(EMPTY));
        // Entry setup so a spurious edge would load 7.
        loadn = 1'b0;
        bcd   = 4'd7;
        @(negedge clk);
        clearn = 1'b1;
        repeat (10) @(negedge clk);
        check("held_pgt_no_step", 32'(digits()), 32'h000);
        pgt_1Hz = 1'b0;
        repeat (4) @(negedge clk);
        pulse(4'd7, dn);
        check("fresh_edge_step", 32'(digits()), 32'h007);
        check("fresh_edge_state", 32'(fsm_state), 32'(ENTRY));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Minutes:seconds countdown stage directly downstream of the keypad/timer controller.
- Consumes the controller's bcd, loadn and pgt_1Hz outputs.
- In entry mode it shifts keyed digits right-to-left into a 3-digit M:SS register; in run mode it decrements once per pgt_1Hz pulse.
- Flags zero and emits a one-cycle done pulse that the magnetron/door control logic uses.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on pgt_1Hz and loadn (minimum 2).
- TENS_WRAP, 5, value reloaded into sec_tens on a borrow from minutes.

Ports:
- clk  input  1  system clock (100 Hz domain); all state changes on rising edge.
- clearn  input  1  asynchronous active-low reset.
- pgt_1Hz  input  1  step strobe from the controller (debounced key in entry mode, 1 Hz in run mode).
- loadn  input  1  low = entry mode (shift bcd in), high = run mode (decrement).
- bcd  input  4  keyed digit; valid 0-9.
- sec_ones  output  4  seconds units digit, BCD.
- sec_tens  output  4  seconds tens digit, BCD 0-9 (entry may exceed 5).
- min_ones  output  4  minutes digit, BCD.
- zero  output  1  high when all three digits are 0.
- done  output  1  one-clk pulse when a decrement reaches 0:00.

Behaviour:
- Reset (clearn=0, async): all digits 0, zero=1, done=0, synchronizer/edge registers 0, FSM=EMPTY.
- Input path: pgt_1Hz and loadn each pass through SYNC_STAGES flops; bcd is sampled raw (the controller holds it stable while loadn is low).
- step = synced pgt high AND previous synced pgt low.
- Action occurs on the clk edge where step=1, using synced loadn; digits visible SYNC_STAGES+1 clk edges after pgt_1Hz is first sampled high.
- Entry (step, loadn_s=0, bcd<=9): min_ones<=sec_tens; sec_tens<=sec_ones; sec_ones<=bcd.
  - Fourth and later digits discard the old min_ones.
  - bcd>9: no change.
- Run (step, loadn_s=1, not zero), borrow-chain decrement:
  - sec_ones 0 -> 9 with borrow, else -1.
  - sec_tens on borrow: 0 -> TENS_WRAP with borrow, else -1.
  - min_ones on borrow: -1.
  - An entered tens value of 6-9 counts down normally (99 s counts 99, 98, ...).
- Run at 0:00: no change, no done.
- done=1 for exactly one clk on the edge where digits transition from non-zero to 0:00 via decrement. Never asserted by entry or reset.
- zero is combinational from the digit registers.
- FSM (status only; the datapath rules above govern):
  - EMPTY (zero): step+entry -> ENTRY if bcd non-zero or any digit non-zero.
  - ENTRY: step+run -> RUN; entry of 0 into 0:00 stays EMPTY.
  - RUN: decrement to 0 -> DONE.
  - DONE: next clk -> EMPTY.
  - Any step with loadn_s=0 in RUN -> ENTRY (pause/edit).
- Simultaneous loadn change and pgt edge: the synced loadn value on the step cycle decides; no partial update.
- clearn mid-count: immediate clear; the next step after release is treated as a fresh edge only if pgt is sampled low first.

Decomposition:
- Shared package timer_pkg: BCD_MAX=9, FSM state encoding (EMPTY, ENTRY, RUN, DONE), digit width 4.
- Sub-module bcd_down_digit (ports: clk, clearn, load, load_val, dec, wrap_val → q, borrow_out): instantiated three times.
  - min_ones wrap_val is unused; decrement is gated by zero.

Test Plan:
- Reset: clearn=0 with pgt toggling -> digits 0:00, zero=1, done=0.
- Entry: loadn=0, keys 1,3,0 each with one pgt pulse -> 1:30 after third step; bcd=4'hC pulse -> unchanged 1:30.
- Borrow: load 1:00, loadn=1, one pgt pulse -> 0:59; pulses continue to 0:01 then 0:00.
  - done high exactly one clk; further pulses leave 0:00, done stays 0.
- Large tens: load 0:99, run 10 pulses -> 0:89; from 1:05 five pulses -> 1:00, next -> 0:59.
- Overflow entry: keys 1,2,3,4 -> 2:34.
- Mid-run reset: 0:45 counting, clearn pulsed low -> 0:00 immediately; a held-high pgt after release produces no step until it goes low then high.
